// File: rtl/stage_wb_pkg.sv
// Shared constants and encodings for the AdamRiscv write-back stage.
// Holds the w_select codes and the matrix-row gather FSM states.
package stage_wb_pkg;

  localparam int XLEN   = 32;
  localparam int MLANES = 4;
  localparam int LANE_W = 2;
  localparam int RD_W   = 5;

  localparam logic [1:0] W_SEL_ALU = 2'b00;
  localparam logic [1:0] W_SEL_PC4 = 2'b01;
  localparam logic [1:0] W_SEL_MEM = 2'b10;
  localparam logic [1:0] W_SEL_MAT = 2'b11;

  typedef enum logic [1:0] {
    WB_IDLE   = 2'b00,
    WB_GATHER = 2'b01,
    WB_COMMIT = 2'b10
  } wb_state_e;

endpackage

// File: rtl/stage_wb_matrix_row_gather.sv
// Collects 32-bit matrix beats into a 128-bit row and emits a one-cycle
// commit pulse with the assembled row once the beat flagged last arrives.
module stage_wb_matrix_row_gather
  import stage_wb_pkg::*;
#(
  parameter int XLEN   = stage_wb_pkg::XLEN,
  parameter int MLANES = stage_wb_pkg::MLANES,
  parameter int LANE_W = stage_wb_pkg::LANE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   beat_ok,
  input  logic                   flush,
  input  logic [LANE_W-1:0]      lane,
  input  logic                   mlast,
  input  logic [RD_W-1:0]        rd,
  input  logic [XLEN-1:0]        data,
  output logic [XLEN*MLANES-1:0] row_data,
  output logic [RD_W-1:0]        row_rd,
  output logic                   row_commit,
  output logic                   row_partial,
  output logic                   busy
);

  wb_state_e               state_r;
  logic [XLEN*MLANES-1:0]  buf_r;
  logic [MLANES-1:0]       lane_valid_r;
  logic [RD_W-1:0]         rd_r;
  logic [XLEN*MLANES-1:0]  row_data_r;
  logic                    row_commit_r;
  logic                    row_partial_r;

  logic [XLEN*MLANES-1:0]  buf_nxt_s;
  logic [MLANES-1:0]       lane_valid_nxt_s;
  logic                    first_beat_s;
  logic [RD_W-1:0]         rd_first_s;

  // Buffer contents and row rd as they would look after merging this beat.
  always_comb begin
    buf_nxt_s        = buf_r;
    lane_valid_nxt_s = lane_valid_r;
    if (beat_ok) begin
      buf_nxt_s[int'(lane)*XLEN +: XLEN] = data;
      lane_valid_nxt_s[lane]             = 1'b1;
    end else begin
      buf_nxt_s        = buf_r;
      lane_valid_nxt_s = lane_valid_r;
    end
    case (state_r)
      WB_GATHER: first_beat_s = 1'b0;
      WB_IDLE:   first_beat_s = 1'b1;
      WB_COMMIT: first_beat_s = 1'b1;
      default:   first_beat_s = 1'b1;
    endcase
    if (first_beat_s) begin
      rd_first_s = rd;
    end else begin
      rd_first_s = rd_r;
    end
  end

  // Gather FSM: accumulate beats, commit on the last one, abort on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= WB_IDLE;
      buf_r         <= '0;
      lane_valid_r  <= '0;
      rd_r          <= '0;
      row_data_r    <= '0;
      row_commit_r  <= 1'b0;
      row_partial_r <= 1'b0;
    end else begin
      row_commit_r  <= 1'b0;
      row_partial_r <= 1'b0;
      if (flush) begin
        state_r      <= WB_IDLE;
        buf_r        <= '0;
        lane_valid_r <= '0;
      end else if (beat_ok) begin
        rd_r <= rd_first_s;
        if (mlast) begin
          // Unwritten lanes are already zero because the buffer is cleared per row.
          row_data_r    <= buf_nxt_s;
          row_commit_r  <= 1'b1;
          row_partial_r <= ~&lane_valid_nxt_s;
          buf_r         <= '0;
          lane_valid_r  <= '0;
          state_r       <= WB_COMMIT;
        end else begin
          buf_r        <= buf_nxt_s;
          lane_valid_r <= lane_valid_nxt_s;
          state_r      <= WB_GATHER;
        end
      end else begin
        case (state_r)
          WB_GATHER: state_r <= WB_GATHER;
          WB_COMMIT: state_r <= WB_IDLE;
          WB_IDLE:   state_r <= WB_IDLE;
          default:   state_r <= WB_IDLE;
        endcase
      end
    end
  end

  assign row_data    = row_data_r;
  assign row_rd      = rd_r;
  assign row_commit  = row_commit_r;
  assign row_partial = row_partial_r;
  assign busy        = (state_r == WB_GATHER);

endmodule

// File: rtl/stage_wb.sv
// Write-back stage: MEM/WB register, scalar write-back mux and the
// matrix-row gather that feeds the matrix register file.
module stage_wb
  import stage_wb_pkg::*;
#(
  parameter int XLEN   = stage_wb_pkg::XLEN,
  parameter int MLANES = stage_wb_pkg::MLANES,
  parameter int LANE_W = stage_wb_pkg::LANE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   me_valid,
  input  logic [1:0]             me_w_select,
  input  logic [XLEN-1:0]        me_alu_o,
  input  logic [XLEN-1:0]        me_pc4,
  input  logic [XLEN-1:0]        me_mem_data,
  input  logic [RD_W-1:0]        me_rd,
  input  logic                   me_regs_write,
  input  logic [LANE_W-1:0]      me_lane,
  input  logic                   me_mlast,
  input  logic                   wb_stall,
  input  logic                   wb_flush,
  output logic [1:0]             wb_w_select,
  output logic [RD_W-1:0]        wb_rd,
  output logic                   wb_regs_write,
  output logic [XLEN-1:0]        w_regs_data,
  output logic                   wb_matrix_write,
  output logic [XLEN*MLANES-1:0] w_matrix_data,
  output logic                   wb_partial,
  output logic                   wb_busy
);

  logic              accept_s;
  logic              mat_beat_s;
  logic [XLEN-1:0]   scalar_data_s;
  logic [RD_W-1:0]   row_rd_s;
  logic              gather_busy_s;

  logic [1:0]        wb_w_select_r;
  logic [RD_W-1:0]   wb_rd_r;
  logic              wb_regs_write_r;
  logic [XLEN-1:0]   w_regs_data_r;

  // Beat acceptance and scalar source selection.
  always_comb begin
    accept_s   = me_valid & ~wb_stall & ~wb_flush;
    mat_beat_s = accept_s & (me_w_select == W_SEL_MAT);
    case (me_w_select)
      W_SEL_ALU: scalar_data_s = me_alu_o;
      W_SEL_PC4: scalar_data_s = me_pc4;
      W_SEL_MEM: scalar_data_s = me_mem_data;
      default:   scalar_data_s = me_alu_o;
    endcase
  end

  // MEM/WB register; a matrix commit also drives rd/select for forwarding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_w_select_r   <= 2'b00;
      wb_rd_r         <= '0;
      wb_regs_write_r <= 1'b0;
      w_regs_data_r   <= '0;
    end else begin
      wb_regs_write_r <= 1'b0;
      if (accept_s && (me_w_select != W_SEL_MAT)) begin
        w_regs_data_r   <= scalar_data_s;
        wb_rd_r         <= me_rd;
        wb_w_select_r   <= me_w_select;
        wb_regs_write_r <= me_regs_write & (me_rd != 5'd0);
      end else if (mat_beat_s && me_mlast) begin
        wb_rd_r       <= gather_busy_s ? row_rd_s : me_rd;
        wb_w_select_r <= W_SEL_MAT;
      end else begin
        wb_rd_r       <= wb_rd_r;
        wb_w_select_r <= wb_w_select_r;
      end
    end
  end

  stage_wb_matrix_row_gather #(
    .XLEN   (XLEN),
    .MLANES (MLANES),
    .LANE_W (LANE_W)
  ) u_gather (
    .clk         (clk),
    .rst         (rst),
    .beat_ok     (mat_beat_s),
    .flush       (wb_flush),
    .lane        (me_lane),
    .mlast       (me_mlast),
    .rd          (me_rd),
    .data        (me_mem_data),
    .row_data    (w_matrix_data),
    .row_rd      (row_rd_s),
    .row_commit  (wb_matrix_write),
    .row_partial (wb_partial),
    .busy        (gather_busy_s)
  );

  assign wb_w_select   = wb_w_select_r;
  assign wb_rd         = wb_rd_r;
  assign wb_regs_write = wb_regs_write_r;
  assign w_regs_data   = w_regs_data_r;
  assign wb_busy       = gather_busy_s;

endmodule

// File: tb/tb_stage_wb.sv
// Directed plus randomized bench for stage_wb with a lane-array reference model.
module tb_stage_wb;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         me_valid = 1'b0;
  logic [1:0]   me_w_select = 2'b00;
  logic [31:0]  me_alu_o = 32'h0, me_pc4 = 32'h0, me_mem_data = 32'h0;
  logic [4:0]   me_rd = 5'd0;
  logic         me_regs_write = 1'b0;
  logic [1:0]   me_lane = 2'd0;
  logic         me_mlast = 1'b0;
  logic         wb_stall = 1'b0;
  logic         wb_flush = 1'b0;
  logic [1:0]   wb_w_select;
  logic [4:0]   wb_rd;
  logic         wb_regs_write;
  logic [31:0]  w_regs_data;
  logic         wb_matrix_write;
  logic [127:0] w_matrix_data;
  logic         wb_partial;
  logic         wb_busy;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0]  m_lane [4];
  logic [3:0]   m_lv;
  logic         m_gather;
  logic [4:0]   m_row_rd;
  logic [1:0]   exp_sel;
  logic [4:0]   exp_rd;
  logic         exp_rw;
  logic [31:0]  exp_wdata;
  logic         exp_mw;
  logic [127:0] exp_mdata;
  logic         exp_part;
  logic         exp_busy;

  stage_wb dut (
    .clk(clk), .rst(rst), .me_valid(me_valid), .me_w_select(me_w_select),
    .me_alu_o(me_alu_o), .me_pc4(me_pc4), .me_mem_data(me_mem_data),
    .me_rd(me_rd), .me_regs_write(me_regs_write), .me_lane(me_lane),
    .me_mlast(me_mlast), .wb_stall(wb_stall), .wb_flush(wb_flush),
    .wb_w_select(wb_w_select), .wb_rd(wb_rd), .wb_regs_write(wb_regs_write),
    .w_regs_data(w_regs_data), .wb_matrix_write(wb_matrix_write),
    .w_matrix_data(w_matrix_data), .wb_partial(wb_partial), .wb_busy(wb_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_lane[i] = 32'h0;
    m_lv = 4'h0; m_gather = 1'b0; m_row_rd = 5'd0;
    exp_sel = 2'b00; exp_rd = 5'd0; exp_rw = 1'b0; exp_wdata = 32'h0;
    exp_mw = 1'b0; exp_mdata = 128'h0; exp_part = 1'b0; exp_busy = 1'b0;
  endtask

  // Applies the rules of one clock edge to the model using the current inputs.
  task automatic model_edge();
    exp_rw = 1'b0; exp_mw = 1'b0; exp_part = 1'b0;
    if (wb_flush) begin
      for (int i = 0; i < 4; i++) m_lane[i] = 32'h0;
      m_lv = 4'h0; m_gather = 1'b0;
    end else if (wb_stall || !me_valid) begin
      exp_rw = 1'b0;
    end else if (me_w_select != 2'b11) begin
      exp_wdata = (me_w_select == 2'b00) ? me_alu_o :
                  (me_w_select == 2'b01) ? me_pc4 : me_mem_data;
      exp_rd  = me_rd;
      exp_sel = me_w_select;
      exp_rw  = me_regs_write && (me_rd != 5'd0);
    end else begin
      if (!m_gather) m_row_rd = me_rd;
      m_lane[me_lane] = me_mem_data;
      m_lv[me_lane] = 1'b1;
      if (me_mlast) begin
        exp_mdata = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
        exp_mw   = 1'b1;
        exp_part = (m_lv != 4'hF);
        exp_rd   = m_row_rd;
        exp_sel  = 2'b11;
        for (int i = 0; i < 4; i++) m_lane[i] = 32'h0;
        m_lv = 4'h0; m_gather = 1'b0;
      end else begin
        m_gather = 1'b1;
      end
    end
    exp_busy = m_gather;
  endtask

  task automatic check_all();
    check("wb_w_select", 128'(wb_w_select), 128'(exp_sel));
    check("wb_rd", 128'(wb_rd), 128'(exp_rd));
    check("wb_regs_write", 128'(wb_regs_write), 128'(exp_rw));
    check("w_regs_data", 128'(w_regs_data), 128'(exp_wdata));
    check("wb_matrix_write", 128'(wb_matrix_write), 128'(exp_mw));
    check("w_matrix_data", w_matrix_data, exp_mdata);
    check("wb_partial", 128'(wb_partial), 128'(exp_part));
    check("wb_busy", 128'(wb_busy), 128'(exp_busy));
  endtask

  // One clock: drive inputs, clock edge, advance model, sample 1ns later.
  // The value d goes to the selected source; other sources get distinct values.
  task automatic step(input logic v, input logic [1:0] sel, input logic [31:0] d,
                      input logic [4:0] rd, input logic rw, input logic [1:0] lane,
                      input logic ml, input logic st, input logic fl);
    me_valid = v; me_w_select = sel; me_rd = rd; me_regs_write = rw;
    me_lane = lane; me_mlast = ml; wb_stall = st; wb_flush = fl;
    me_alu_o    = (sel == 2'b00) ? d : d ^ 32'h0F0F_0001;
    me_pc4      = (sel == 2'b01) ? d : d ^ 32'hF0F0_0002;
    me_mem_data = (sel[1] == 1'b1) ? d : d ^ 32'h5A5A_0004;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Scalar load
    step(1'b1, 2'b10, 32'hDEADBEEF, 5'd5, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    check("load_data", 128'(w_regs_data), 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    idle();
    // x0 write suppressed, PC+4 path
    step(1'b1, 2'b01, 32'h0000_1004, 5'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);

    // Full row
    step(1'b1, 2'b11, 32'h11111111, 5'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'h22222222, 5'd9, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'h33333333, 5'd9, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'h44444444, 5'd9, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
    check("full_row", w_matrix_data, 128'h44444444_33333333_22222222_11111111);
    idle();

    // Partial row: lanes 0 and 2
    step(1'b1, 2'b11, 32'hAAAA0000, 5'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'hCCCC0000, 5'd3, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    check("partial_row", w_matrix_data, 128'h00000000_CCCC0000_00000000_AAAA0000);
    idle();

    // Interleave scalar and stall inside a gather
    step(1'b1, 2'b11, 32'h01010101, 5'd4, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 32'h00001234, 5'd7, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'h02020202, 5'd4, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 2'b11, 32'h02020202, 5'd4, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 2'b11, 32'h02020202, 5'd4, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'h03030303, 5'd4, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'h04040404, 5'd4, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);

    // Flush mid-gather, then a clean row
    step(1'b1, 2'b11, 32'h55555555, 5'd6, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'h66666666, 5'd6, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'h77777777, 5'd6, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1);
    step(1'b1, 2'b11, 32'h88888888, 5'd8, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-gather
    step(1'b1, 2'b11, 32'h99999999, 5'd10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'hAAAAAAAA, 5'd10, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    me_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 2'b11, 32'hBBBBBBBB, 5'd11, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);

    // Back-to-back rows, second row starts in the commit cycle
    step(1'b1, 2'b11, 32'hC0000000, 5'd12, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'hC1111111, 5'd12, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'hD0000000, 5'd13, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'hD3333333, 5'd13, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
    // Flush in the commit cycle keeps the pulse already issued
    step(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    idle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)), $urandom(),
           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) < 3),
           1'($urandom_range(0, 9) < 1), 1'($urandom_range(0, 19) < 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
